// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared framebuffer geometry, pixel/address types and fill FSM states
package vga_pkg;

    localparam int FB_WIDTH  = 214;
    localparam int FB_HEIGHT = 160;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    typedef logic [15:0] fb_addr_t;
    typedef logic [2:0]  pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fill_state_t;

endpackage

// File: rtl/fb_rect_fill_if.sv
// rtl/fb_rect_fill_if.sv - rectangle command handshake plus framebuffer write port
interface fb_rect_fill_if #(
    parameter int ADDR_W  = 16,
    parameter int COLOR_W = 3
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_x;
    logic [7:0]         cmd_y;
    logic [7:0]         cmd_w;
    logic [7:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;

    logic               fb_we;
    logic               fb_wready;
    logic [ADDR_W-1:0]  fb_waddr;
    logic [COLOR_W-1:0] fb_wdata;

    logic               busy;
    logic               done;

    // master: command issuer and framebuffer; slave: the fill engine
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_wready,
        input  cmd_ready, fb_we, fb_waddr, fb_wdata, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_wready,
        output cmd_ready, fb_we, fb_waddr, fb_wdata, busy, done
    );

endinterface

// File: rtl/fb_rect_fill_clip.sv
// rtl/fb_rect_fill_clip.sv - clips a rectangle to the framebuffer and computes its first-line address
module fb_rect_fill_clip #(
    parameter int FB_WIDTH  = 214,
    parameter int FB_HEIGHT = 160,
    parameter int ADDR_W    = 16
) (
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [7:0]        w,
    input  logic [7:0]        h,
    output logic              is_null,
    output logic [7:0]        w_eff,
    output logic [7:0]        h_eff,
    output logic [ADDR_W-1:0] row_base
);

    // 9-bit intermediates so an origin near the edge cannot wrap the remaining span
    logic [8:0] x_ext;
    logic [8:0] y_ext;
    logic [8:0] rem_w;
    logic [8:0] rem_h;
    logic       x_out;
    logic       y_out;

    always_comb begin
        x_ext = {1'b0, x};
        y_ext = {1'b0, y};
        x_out = (x_ext >= 9'(FB_WIDTH));
        y_out = (y_ext >= 9'(FB_HEIGHT));
        rem_w = 9'(FB_WIDTH) - x_ext;
        rem_h = 9'(FB_HEIGHT) - y_ext;

        is_null = x_out || y_out || (w == 8'd0) || (h == 8'd0);

        w_eff = ({1'b0, w} > rem_w) ? rem_w[7:0] : w;
        h_eff = ({1'b0, h} > rem_h) ? rem_h[7:0] : h;

        row_base = ADDR_W'(y) * ADDR_W'(FB_WIDTH) + ADDR_W'(x);
    end

endmodule

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - solid rectangle fill engine writing into the scan-out framebuffer
module fb_rect_fill #(
    parameter int FB_WIDTH  = vga_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = vga_pkg::FB_HEIGHT,
    parameter int ADDR_W    = 16,
    parameter int COLOR_W   = 3
) (
    input  logic         clk,
    input  logic         rst_async,
    fb_rect_fill_if.slave bus
);

    import vga_pkg::*;

    fill_state_t state_q;
    fill_state_t state_d;

    logic [7:0]         x_q;
    logic [7:0]         y_q;
    logic [7:0]         w_q;
    logic [7:0]         h_q;
    logic [COLOR_W-1:0] color_q;

    logic [7:0]         w_eff_q;
    logic [7:0]         h_eff_q;
    logic [7:0]         col_q;
    logic [7:0]         row_q;
    logic [ADDR_W-1:0]  row_base_q;

    logic               fb_we_q;
    logic [ADDR_W-1:0]  fb_waddr_q;
    logic [COLOR_W-1:0] fb_wdata_q;

    logic               clip_null;
    logic [7:0]         clip_w;
    logic [7:0]         clip_h;
    logic [ADDR_W-1:0]  clip_base;

    logic               last_col;
    logic               last_pix;

    fb_rect_fill_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .ADDR_W    (ADDR_W)
    ) u_clip (
        .x        (x_q),
        .y        (y_q),
        .w        (w_q),
        .h        (h_q),
        .is_null  (clip_null),
        .w_eff    (clip_w),
        .h_eff    (clip_h),
        .row_base (clip_base)
    );

    assign last_col = (col_q == w_eff_q - 8'd1);
    assign last_pix = last_col && (row_q == h_eff_q - 8'd1);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = SETUP;
            SETUP:   state_d = clip_null ? DONE : FILL;
            FILL:    if (bus.fb_wready && last_pix) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write-port outputs are loaded one step ahead so they never depend combinationally on fb_wready
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            w_eff_q    <= '0;
            h_eff_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            fb_we_q    <= 1'b0;
            fb_waddr_q <= '0;
            fb_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x_q     <= bus.cmd_x;
                        y_q     <= bus.cmd_y;
                        w_q     <= bus.cmd_w;
                        h_q     <= bus.cmd_h;
                        color_q <= bus.cmd_color;
                    end
                end
                SETUP: begin
                    w_eff_q    <= clip_w;
                    h_eff_q    <= clip_h;
                    row_base_q <= clip_base;
                    col_q      <= '0;
                    row_q      <= '0;
                    if (!clip_null) begin
                        fb_we_q    <= 1'b1;
                        fb_waddr_q <= clip_base;
                        fb_wdata_q <= color_q;
                    end
                end
                FILL: begin
                    if (bus.fb_wready) begin
                        if (last_pix) begin
                            fb_we_q <= 1'b0;
                        end else if (last_col) begin
                            col_q      <= '0;
                            row_q      <= row_q + 8'd1;
                            row_base_q <= row_base_q + ADDR_W'(FB_WIDTH);
                            fb_waddr_q <= row_base_q + ADDR_W'(FB_WIDTH);
                        end else begin
                            col_q      <= col_q + 8'd1;
                            fb_waddr_q <= fb_waddr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    fb_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_waddr  = fb_waddr_q;
    assign bus.fb_wdata  = fb_wdata_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - directed vector bench for the rectangle fill engine
module tb_fb_rect_fill;

    logic clk = 1'b0;
    logic rst_async;

    fb_rect_fill_if bus ();

    fb_rect_fill dut (
        .clk       (clk),
        .rst_async (rst_async),
        .bus       (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        logic [2:0] c;
        int         n;
        int         first;
        int         last;
        longint     sum;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    logic [15:0] wr_addr_q[$];
    logic [2:0]  wr_data_q[$];

    always @(negedge clk) begin
        if (!rst_async && bus.fb_we && bus.fb_wready) begin
            wr_addr_q.push_back(bus.fb_waddr);
            wr_data_q.push_back(bus.fb_wdata);
        end
        if (!rst_async && bus.done) n_done++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                           input logic [7:0] h, input logic [2:0] c, output int lat);
        int guard;
        wr_addr_q.delete();
        wr_data_q.delete();
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.done && lat < 40000);
    endtask

    initial begin
        int lat;
        int bad;
        int edges;
        int seen;
        int done_at[2];
        int nd;
        int qs;
        longint s;
        int a_exp[6];
        int b_exp[4];

        vecs[0] = '{x: 10,  y: 20,  w: 3,   h: 2,   c: 2, n: 6,   first: 4290,  last: 4506,  sum: 26388,   lat: 7};
        vecs[1] = '{x: 212, y: 158, w: 5,   h: 5,   c: 7, n: 4,   first: 34024, last: 34239, sum: 136526,  lat: 5};
        vecs[2] = '{x: 214, y: 0,   w: 10,  h: 10,  c: 1, n: 0,   first: 0,     last: 0,     sum: 0,       lat: 1};
        vecs[3] = '{x: 0,   y: 0,   w: 0,   h: 5,   c: 3, n: 0,   first: 0,     last: 0,     sum: 0,       lat: 1};
        vecs[4] = '{x: 0,   y: 159, w: 255, h: 255, c: 4, n: 214, first: 34026, last: 34239, sum: 7304355, lat: 215};
        vecs[5] = '{x: 213, y: 0,   w: 1,   h: 1,   c: 6, n: 1,   first: 213,   last: 213,   sum: 213,     lat: 2};
        vecs[6] = '{x: 0,   y: 160, w: 3,   h: 3,   c: 5, n: 0,   first: 0,     last: 0,     sum: 0,       lat: 1};
        vecs[7] = '{x: 100, y: 50,  w: 1,   h: 3,   c: 1, n: 3,   first: 10800, last: 11228, sum: 33042,   lat: 4};
        a_exp = '{4290, 4291, 4292, 4504, 4505, 4506};
        b_exp = '{34024, 34025, 34238, 34239};

        rst_async     = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        bus.fb_wready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset cmd_ready", bus.cmd_ready, 1);
        check("reset fb_we", bus.fb_we, 0);
        check("reset fb_waddr", bus.fb_waddr, 0);
        check("reset fb_wdata", bus.fb_wdata, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        rst_async = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, lat);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d writes", i), wr_addr_q.size(), vecs[i].n);
            s = 0;
            bad = 0;
            foreach (wr_addr_q[k]) begin
                s += wr_addr_q[k];
                if (wr_data_q[k] != vecs[i].c) bad++;
            end
            check($sformatf("v%0d addr sum", i), s, vecs[i].sum);
            check($sformatf("v%0d bad data", i), bad, 0);
            if (vecs[i].n > 0 && wr_addr_q.size() > 0) begin
                check($sformatf("v%0d first addr", i), wr_addr_q[0], vecs[i].first);
                check($sformatf("v%0d last addr", i), wr_addr_q[wr_addr_q.size()-1], vecs[i].last);
            end
            tick();
        end

        // Backpressure on the second write of the small rectangle
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.cmd_x = 10; bus.cmd_y = 20; bus.cmd_w = 3; bus.cmd_h = 2; bus.cmd_color = 2;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("bp fb_we in setup", bus.fb_we, 0);
        @(posedge clk);
        @(negedge clk);
        check("bp first fb_we", bus.fb_we, 1);
        check("bp first addr", bus.fb_waddr, 4290);
        @(posedge clk);
        #1 bus.fb_wready = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.fb_waddr != 16'd4291 || bus.fb_we != 1'b1 || bus.fb_wdata != 3'd2) bad++;
            @(posedge clk);
        end
        #1 bus.fb_wready = 1'b1;
        lat = 5;
        do begin
            @(negedge clk);
            if (bus.done) break;
            @(posedge clk);
            lat++;
        end while (lat < 100);
        check("bp held cycles bad", bad, 0);
        check("bp latency", lat, 10);
        check("bp writes", wr_addr_q.size(), 6);
        bad = 0;
        foreach (wr_addr_q[k]) if (k < 6 && wr_addr_q[k] != a_exp[k]) bad++;
        check("bp order bad", bad, 0);
        tick();

        // Second command held valid through the first fill
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.cmd_x = 10; bus.cmd_y = 20; bus.cmd_w = 3; bus.cmd_h = 2; bus.cmd_color = 2;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_x = 212; bus.cmd_y = 158; bus.cmd_w = 5; bus.cmd_h = 5; bus.cmd_color = 7;
        edges = 0;
        seen = 0;
        done_at = '{0, 0};
        while (seen < 2 && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 3) check("hs cmd_ready during fill", bus.cmd_ready, 0);
            if (bus.done) begin
                done_at[seen] = edges;
                seen++;
            end
        end
        bus.cmd_valid = 1'b0;
        check("hs first done", done_at[0], 7);
        check("hs second done", done_at[1], 14);
        check("hs writes", wr_addr_q.size(), 10);
        bad = 0;
        foreach (wr_addr_q[k]) begin
            if (k < 6 && (wr_addr_q[k] != a_exp[k] || wr_data_q[k] != 3'd2)) bad++;
            if (k >= 6 && k < 10 && (wr_addr_q[k] != b_exp[k-6] || wr_data_q[k] != 3'd7)) bad++;
        end
        check("hs sequence bad", bad, 0);
        tick();
        tick();

        // Full-screen clear
        run_cmd(8'd0, 8'd0, 8'd214, 8'd160, 3'd5, lat);
        check("clear latency", lat, 34241);
        check("clear writes", wr_addr_q.size(), 34240);
        bad = 0;
        foreach (wr_addr_q[k]) if (wr_addr_q[k] != 16'(k) || wr_data_q[k] != 3'b101) bad++;
        check("clear contiguity bad", bad, 0);
        @(posedge clk);
        @(negedge clk);
        check("clear busy after done", bus.busy, 0);
        check("clear done one cycle", bus.done, 0);
        tick();

        // Reset in the middle of a full clear
        wr_addr_q.delete();
        wr_data_q.delete();
        bus.cmd_x = 0; bus.cmd_y = 0; bus.cmd_w = 214; bus.cmd_h = 160; bus.cmd_color = 5;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("mid fill fb_we", bus.fb_we, 1);
        nd = n_done;
        #2 rst_async = 1'b1;
        #1;
        check("async rst fb_we", bus.fb_we, 0);
        check("async rst busy", bus.busy, 0);
        check("async rst cmd_ready", bus.cmd_ready, 1);
        qs = wr_addr_q.size();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_async = 1'b0;
        repeat (5) tick();
        check("rst no done", n_done, nd);
        check("rst no writes", wr_addr_q.size(), qs);
        run_cmd(8'd213, 8'd0, 8'd1, 8'd1, 3'd6, lat);
        check("post rst latency", lat, 2);
        check("post rst writes", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("post rst addr", wr_addr_q[0], 213);
            check("post rst data", wr_data_q[0], 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
